// File: rtl/fsm_share_arb.sv
// Round-robin owner of one shared two-input Mealy FSM unit: grants it to one
// requester at a time, routes that requester's {a,b} in and {m,n} back.
module fsm_share_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] ab_in,
  input  logic           fsm_m,
  input  logic           fsm_n,
  output logic [N-1:0]   gnt,
  output logic           fsm_a,
  output logic           fsm_b,
  output logic           fsm_rst_b,
  output logic [1:0]     mn_out,
  output logic           mn_valid,
  output logic           timeout,
  output logic [1:0]     state_dbg
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [N-1:0]  gnt_n;
  logic          rst_b_n;
  logic          timeout_n;

  logic [PW-1:0] win;
  logic          win_vld;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Handshake: req is a level held while the requester wants the unit; gnt[i]
  // high means slice i of ab_in drives the unit and mn_out/mn_valid belong to
  // requester i. A low req sampled at an edge ends ownership at that edge.

  // Rotating priority search starting at ptr.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    rst_b_n   = fsm_rst_b;
    timeout_n = 1'b0;
    case (state)
      GRANT: begin
        // Voluntary drop has priority: timeout only fires if req is still high.
        if (!req[owner] || hold_cnt == HW'(MAX_HOLD - 1)) begin
          state_n   = GAP;
          gnt_n     = '0;
          rst_b_n   = 1'b0;
          ptr_n     = (owner == LAST) ? '0 : owner + PW'(1);
          timeout_n = req[owner];
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        gnt_n = '0;
        if (win_vld) begin
          state_n    = GRANT;
          owner_n    = win;
          gnt_n[win] = 1'b1;
          rst_b_n    = 1'b1;
          hold_n     = '0;
        end else begin
          state_n = IDLE;
          rst_b_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      fsm_rst_b <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      fsm_rst_b <= rst_b_n;
      timeout   <= timeout_n;
    end
  end

  always_comb begin
    fsm_a = 1'b0;
    fsm_b = 1'b0;
    if (state == GRANT) begin
      fsm_a = ab_in[{owner, 1'b1}];
      fsm_b = ab_in[{owner, 1'b0}];
    end
  end

  assign mn_out    = {fsm_m, fsm_n};
  assign mn_valid  = (state == GRANT);
  assign state_dbg = state;

endmodule

// File: doc/fsm_share_arb.md
Name: fsm_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one two-input Mealy FSM unit (inputs a/b, outputs m/n, active-low async reset) between N requesters.
- Grants the unit to one requester at a time and muxes that requester's {a,b} stimulus onto the unit.
- Returns the unit's {m,n} to the owner.
- Resets the unit between owners so every owner starts from its initial state.
- Bounds ownership with a hold timeout.

Parameters:
N, 4, number of requesters (2..8)
MAX_HOLD, 8, maximum consecutive GRANT cycles per ownership (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  N  per-requester request level; held high while the requester wants the unit
ab_in  input  2N  stimulus; bits [2i+1:2i] = {a,b} of requester i
fsm_m  input  1  m output of shared FSM unit
fsm_n  input  1  n output of shared FSM unit
gnt  output  N  registered one-hot grant (all zero when unowned)
fsm_a  output  1  a input to shared FSM unit
fsm_b  output  1  b input to shared FSM unit
fsm_rst_b  output  1  registered active-low reset to shared FSM unit
mn_out  output  2  {fsm_m,fsm_n} forwarded to owner
mn_valid  output  1  high while mn_out belongs to current owner
timeout  output  1  registered one-cycle pulse on forced release

Behaviour:
- Single clock clk; reset rst is asynchronous, active-high.
- While rst is high, and on its release:
  - state=IDLE, gnt=0, fsm_rst_b=0, timeout=0, ptr=0, hold_cnt=0.
  - Combinational outputs follow: fsm_a=fsm_b=0, mn_out={fsm_m,fsm_n}, mn_valid=0.
- State machine: IDLE, GRANT, GAP (encoding free).
- Arbitration (evaluated in IDLE and GAP):
  - Winner = first i with req[i]=1 searching ptr, ptr+1, … mod N.
  - If a winner exists: next state GRANT, gnt<=onehot(winner), fsm_rst_b<=1, hold_cnt<=0.
  - Otherwise: IDLE, gnt<=0, fsm_rst_b<=0.
- Grant latency: req[i] high before edge k gives gnt[i]=1 after edge k (1 cycle).
- GRANT, owner i:
  - fsm_a=ab_in[2i+1], fsm_b=ab_in[2i] (combinational mux).
  - mn_valid=1; hold_cnt increments each edge.
- Release from GRANT (state<=GAP, gnt<=0, fsm_rst_b<=0, ptr<=(i+1) mod N) on either:
  - (a) req[i]=0 sampled at edge: timeout stays 0.
  - (b) req[i]=1 and hold_cnt==MAX_HOLD-1: timeout<=1 for exactly one cycle.
  - If both conditions hold on the same edge, (a) wins and no timeout pulse.
- Maximum ownership is MAX_HOLD cycles of gnt high.
- GAP:
  - Exactly one cycle with gnt=0, fsm_rst_b=0, fsm_a=fsm_b=0, mn_valid=0; clears the shared unit.
  - Arbitrates as IDLE, so handover between owners costs exactly one idle cycle.
- ptr changes only on release. A timed-out requester still holding req is served again only after all other active requesters have had a turn.
- In IDLE and GAP: fsm_a=fsm_b=0, mn_valid=0. req/ab_in of non-owners are ignored.
- hold_cnt width: ceil(log2(MAX_HOLD+1)). It never wraps because release occurs at MAX_HOLD-1.
- Reset mid-GRANT: all outputs return to reset values immediately (async), fsm_rst_b=0 asserts at once, ptr returns to 0.
- gnt is never multi-hot. fsm_rst_b is high only in GRANT.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, req=4'b0100 from cycle 3 with ab_in[5:4]=2'b10. Required:
  - gnt=4'b0100 and fsm_rst_b=1 one edge later.
  - fsm_a=1, fsm_b=0, mn_valid=1.
  - With req dropped after 3 cycles: gnt low for 1 GAP cycle, then IDLE; timeout never pulses.
- Round-robin: req=4'b1111 held constantly, MAX_HOLD=8. Required:
  - Grants in order 0,1,2,3,0, each exactly 8 cycles.
  - One gnt=0 cycle between owners with fsm_rst_b=0.
  - timeout pulses once per handover.
- Fairness after voluntary release: req0 high for 3 cycles then low, req1 and req2 high. Required:
  - Order 0,1,2 (ptr=1 after owner 0).
  - Owner 0 released with timeout=0.
- Simultaneous drop and timeout: req3 deasserted on the same edge hold_cnt reaches 7. Required: release, timeout=0.
- Reset mid-operation: assert rst during GRANT of requester 2. Required:
  - gnt=0, fsm_rst_b=0, mn_valid=0 without waiting for a clock edge.
  - After release with req=4'b0110: requester 1 is granted first (ptr=0).
- Stimulus mux isolation: owner 1 with ab_in[3:2]=2'b11 while other slices toggle. Required:
  - fsm_a=fsm_b=1 throughout GRANT.
  - mn_out tracks {fsm_m,fsm_n} each cycle.
  - mn_valid drops in GAP.
